master_fsm_mc: RTL and testbench

Multi-channel successor to the correlator master control FSM. It sequences coefficient init, clock-generator setup, host connect/acknowledge, a multi-byte sample-count load, a correlation run across NUM_CH correlator channels with a start-watchdog, and per-channel result transmission. It sits between the command decoder, UART, init_coeff, send_results and the correlator array. It drives control-register muxes, write strobes and the UART source select.

---
 rtl/master_fsm_mc_pkg.sv | 25 ++
 rtl/master_fsm_mc_if.sv | 45 ++++
 rtl/master_fsm_mc_watchdog.sv | 22 ++
 rtl/master_fsm_mc.sv | 164 ++++++++++++++++
 tb/tb_master_fsm_mc.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/master_fsm_mc_pkg.sv
// Shared encodings for the multi-channel correlator master FSM.
// State values 0..12 are legal; anything else decodes back to S_RESET_CORR.
package master_pkg;

  typedef enum logic [3:0] {
    S_RESET_CORR       = 4'd0,
    S_INIT_COEFF       = 4'd1,
    S_INIT_CLK_GEN     = 4'd2,
    S_WAIT_CONN        = 4'd3,
    S_CONN_ACK         = 4'd4,
    S_WAIT_CORR        = 4'd5,
    S_WAIT_SAMPLE_BYTE = 4'd6,
    S_SET_SAMPLES      = 4'd7,
    S_ELAB0            = 4'd8,
    S_WAIT_CORR_BUSY   = 4'd9,
    S_ELAB1            = 4'd10,
    S_SEND0            = 4'd11,
    S_SEND1            = 4'd12
  } state_e;

  localparam logic [1:0] CR_NONE      = 2'b00;
  localparam logic [1:0] CR_STARTSTOP = 2'b10;
  localparam logic [1:0] CR_CLKGEN    = 2'b11;

endpackage

// File: rtl/master_fsm_mc_if.sv
// Command/status bundle between the master FSM and its peripherals.
// The FSM takes the master modport; decoder/UART/correlator side takes slave.
interface master_fsm_mc_if #(
  parameter int NUM_CH       = 4,
  parameter int CH_W         = 2,
  parameter int SAMPLE_BYTES = 2
);
  logic                      start_button;
  logic                      valid;
  logic                      start;
  logic                      connect;
  logic                      sw_reset;
  logic                      set_samples;
  logic [7:0]                rx_data;
  logic                      coeff_busy;
  logic                      send_busy;
  logic                      uart_busy;
  logic [NUM_CH-1:0]         corr_busy;

  logic                      coeff_init;
  logic                      send_start;
  logic [CH_W-1:0]           send_ch;
  logic [1:0]                cr_sel;
  logic                      uart_src_sel;
  logic                      start_uart_tx_mc;
  logic                      we_mc;
  logic                      corr_reset;
  logic [8*SAMPLE_BYTES-1:0] sample_cnt;
  logic                      sample_cnt_we;
  logic                      timeout_err;

  modport master (
    input  start_button, valid, start, connect, sw_reset, set_samples, rx_data,
           coeff_busy, send_busy, uart_busy, corr_busy,
    output coeff_init, send_start, send_ch, cr_sel, uart_src_sel, start_uart_tx_mc,
           we_mc, corr_reset, sample_cnt, sample_cnt_we, timeout_err
  );

  modport slave (
    output start_button, valid, start, connect, sw_reset, set_samples, rx_data,
           coeff_busy, send_busy, uart_busy, corr_busy,
    input  coeff_init, send_start, send_ch, cr_sel, uart_src_sel, start_uart_tx_mc,
           we_mc, corr_reset, sample_cnt, sample_cnt_we, timeout_err
  );
endinterface

// File: rtl/master_fsm_mc_watchdog.sv
// Start watchdog: counts enabled cycles from a clear, flags terminal count
// when the counter reaches TIMEOUT-1.
module mc_watchdog #(
  parameter int TIMEOUT = 1024,
  parameter int W       = $clog2(TIMEOUT+1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + 1'b1;
  end

  assign tc_o = (cnt_q == W'(TIMEOUT-1));
endmodule

// File: rtl/master_fsm_mc.sv
// Master control FSM: coeff init, clock setup, host handshake, sample-count
// load, watchdog-guarded correlation run and per-channel result send.
module master_fsm_mc
  import master_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CH_W         = 2,
  parameter int SAMPLE_BYTES = 2,
  parameter int TIMEOUT      = 1024
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  master_fsm_mc_if.master bus
);
  localparam int SB   = 8*SAMPLE_BYTES;
  localparam int BC_W = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;

  state_e          cs_q, cs_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic [SB-1:0]   sc_q, sc_d;
  logic            terr_q, terr_d;
  logic            wd_clr, wd_en, wd_tc;

  logic       coeff_init, send_start, uart_src_sel, start_uart_tx, we_mc, corr_reset, sc_we;
  logic [1:0] cr_sel;

  mc_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i (sys_clk),
    .rst_ni(sys_rst_n),
    .clr_i (wd_clr),
    .en_i  (wd_en),
    .tc_o  (wd_tc)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cs_q   <= S_RESET_CORR;
      ch_q   <= '0;
      bc_q   <= '0;
      sc_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      cs_q   <= cs_d;
      ch_q   <= ch_d;
      bc_q   <= bc_d;
      sc_q   <= sc_d;
      terr_q <= terr_d;
    end
  end

  always_comb begin
    cs_d          = cs_q;
    ch_d          = ch_q;
    bc_d          = bc_q;
    sc_d          = sc_q;
    terr_d        = terr_q;
    wd_clr        = 1'b0;
    wd_en         = 1'b0;
    coeff_init    = 1'b0;
    send_start    = 1'b0;
    uart_src_sel  = 1'b0;
    start_uart_tx = 1'b0;
    we_mc         = 1'b0;
    corr_reset    = 1'b0;
    sc_we         = 1'b0;
    cr_sel        = CR_NONE;
    case (cs_q)
      S_RESET_CORR: begin
        coeff_init = 1'b1;
        corr_reset = 1'b1;
        cs_d       = S_INIT_COEFF;
      end
      S_INIT_COEFF: begin
        coeff_init = 1'b1;
        if (!bus.coeff_busy) cs_d = S_INIT_CLK_GEN;
      end
      S_INIT_CLK_GEN: begin
        cr_sel = CR_CLKGEN;
        we_mc  = 1'b1;
        cs_d   = S_WAIT_CONN;
      end
      S_WAIT_CONN: begin
        if (bus.valid && bus.connect) begin
          cs_d   = S_CONN_ACK;
          terr_d = 1'b0;
        end else if (bus.valid && bus.sw_reset) cs_d = S_RESET_CORR;
      end
      S_CONN_ACK: begin
        start_uart_tx = 1'b1;
        if (!bus.uart_busy) cs_d = S_WAIT_CORR;
      end
      S_WAIT_CORR: begin
        if ((bus.valid && bus.start) || bus.start_button) cs_d = S_ELAB0;
        else if (bus.valid && bus.sw_reset)               cs_d = S_RESET_CORR;
        else if (bus.valid && bus.set_samples) begin
          cs_d = S_WAIT_SAMPLE_BYTE;
          bc_d = '0;
        end
      end
      // Every valid byte here is payload, even one that decodes as a command.
      S_WAIT_SAMPLE_BYTE: begin
        if (bus.valid) begin
          sc_d = (sc_q << 8) | SB'(bus.rx_data);
          bc_d = bc_q + 1'b1;
          if (bc_q == BC_W'(SAMPLE_BYTES-1)) cs_d = S_SET_SAMPLES;
        end
      end
      S_SET_SAMPLES: begin
        sc_we = 1'b1;
        cs_d  = S_CONN_ACK;
      end
      S_ELAB0: begin
        cr_sel = CR_STARTSTOP;
        we_mc  = 1'b1;
        wd_clr = 1'b1;
        cs_d   = S_WAIT_CORR_BUSY;
      end
      S_WAIT_CORR_BUSY: begin
        if (bus.valid && bus.sw_reset) cs_d = S_RESET_CORR;
        else if (|bus.corr_busy)       cs_d = S_ELAB1;
        else if (wd_tc) begin
          cs_d   = S_RESET_CORR;
          terr_d = 1'b1;
        end else wd_en = 1'b1;
      end
      S_ELAB1: begin
        if (bus.valid && bus.sw_reset) cs_d = S_RESET_CORR;
        else if (bus.corr_busy == '0) begin
          cs_d = S_SEND0;
          ch_d = '0;
        end
      end
      S_SEND0: begin
        send_start   = 1'b1;
        uart_src_sel = 1'b1;
        cs_d         = S_SEND1;
      end
      S_SEND1: begin
        uart_src_sel = 1'b1;
        if (!bus.send_busy) begin
          if (ch_q == CH_W'(NUM_CH-1)) cs_d = S_WAIT_CONN;
          else begin
            ch_d = ch_q + 1'b1;
            cs_d = S_SEND0;
          end
        end
      end
      default: cs_d = S_RESET_CORR;
    endcase
  end

  assign bus.coeff_init       = coeff_init;
  assign bus.send_start       = send_start;
  assign bus.send_ch          = ch_q;
  assign bus.cr_sel           = cr_sel;
  assign bus.uart_src_sel     = uart_src_sel;
  assign bus.start_uart_tx_mc = start_uart_tx;
  assign bus.we_mc            = we_mc;
  assign bus.corr_reset       = corr_reset;
  assign bus.sample_cnt       = sc_q;
  assign bus.sample_cnt_we    = sc_we;
  assign bus.timeout_err      = terr_q;
endmodule

// File: tb/tb_master_fsm_mc.sv
// Directed bench for master_fsm_mc: table-driven bring-up/sample-load vectors
// followed by hand sequences for correlation run, watchdog, sw_reset and async reset.
module tb_master_fsm_mc;
  import master_pkg::*;

  localparam int NUM_CH = 4, CH_W = 2, SAMPLE_BYTES = 2, TIMEOUT = 16;

  // {coeff_init, send_start, uart_src_sel, start_uart_tx_mc, we_mc, corr_reset, sample_cnt_we, cr_sel}
  localparam logic [8:0] O_NONE = 9'b000000000;
  localparam logic [8:0] O_RST  = 9'b100001000;
  localparam logic [8:0] O_COEF = 9'b100000000;
  localparam logic [8:0] O_CLK  = 9'b000010011;
  localparam logic [8:0] O_ACK  = 9'b000100000;
  localparam logic [8:0] O_SETS = 9'b000000100;
  localparam logic [8:0] O_EL0  = 9'b000010010;
  localparam logic [8:0] O_S0   = 9'b011000000;
  localparam logic [8:0] O_S1   = 9'b001000000;

  // {valid, start, connect, sw_reset, set_samples}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_CONN = 5'b10100;
  localparam logic [4:0] C_SET  = 5'b10001;
  localparam logic [4:0] C_DATA = 5'b10000;
  localparam logic [4:0] C_DSW  = 5'b10010;
  localparam logic [4:0] C_STRT = 5'b11000;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int   n_cmp = 0, n_mis = 0;

  master_fsm_mc_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .SAMPLE_BYTES(SAMPLE_BYTES)) bus ();

  master_fsm_mc #(.NUM_CH(NUM_CH), .CH_W(CH_W), .SAMPLE_BYTES(SAMPLE_BYTES), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [3:0]  exp_cs;
    logic [8:0]  exp_o;
    logic [4:0]  cmd;
    logic [7:0]  rx;
    logic        cb;
    logic        ub;
    logic        chk_sc;
    logic [15:0] exp_sc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(state_e s, logic [8:0] o, logic [4:0] c, logic [7:0] rx,
                             logic cb, logic ub, logic chk, logic [15:0] sc);
    vec_t r;
    r.exp_cs = s; r.exp_o = o; r.cmd = c; r.rx = rx;
    r.cb = cb; r.ub = ub; r.chk_sc = chk; r.exp_sc = sc;
    return r;
  endfunction

  function automatic logic [8:0] outs();
    return {bus.coeff_init, bus.send_start, bus.uart_src_sel, bus.start_uart_tx_mc,
            bus.we_mc, bus.corr_reset, bus.sample_cnt_we, bus.cr_sel};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_st(input string nm, input state_e s, input logic [8:0] o);
    chk({nm, ".cs"}, 32'(dut.cs_q), 32'(s));
    chk({nm, ".outs"}, 32'(outs()), 32'(o));
  endtask

  task automatic cmd(input logic [4:0] c, input logic [7:0] rx);
    {bus.valid, bus.start, bus.connect, bus.sw_reset, bus.set_samples} = c;
    bus.rx_data = rx;
  endtask

  task automatic step();
    @(negedge sys_clk);
  endtask

  task automatic send_one(input int k);
    step();
    chk_st("send0", S_SEND0, O_S0);
    chk("send0.ch", 32'(bus.send_ch), 32'(k));
    bus.send_busy = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step();
      chk_st("send1", S_SEND1, O_S1);
      chk("send1.ch", 32'(bus.send_ch), 32'(k));
    end
    bus.send_busy = 1'b0;
  endtask

  initial begin
    int n;
    cmd(C_NONE, 8'h00);
    bus.start_button = 1'b0;
    bus.coeff_busy = 1'b1;
    bus.uart_busy = 1'b0;
    bus.send_busy = 1'b0;
    bus.corr_busy = '0;

    #12;
    chk_st("rst", S_RESET_CORR, O_RST);
    chk("rst.sc", 32'(bus.sample_cnt), 32'h0);
    chk("rst.terr", 32'(bus.timeout_err), 32'h0);
    chk("rst.ch", 32'(bus.send_ch), 32'h0);
    @(posedge sys_clk); #1 sys_rst_n = 1'b1;

    tbl.push_back(v(S_RESET_CORR, O_RST, C_NONE, 8'h00, 1, 0, 0, 16'h0));
    for (int i = 0; i < 4; i++) tbl.push_back(v(S_INIT_COEFF, O_COEF, C_NONE, 8'h00, 1, 0, 0, 16'h0));
    tbl.push_back(v(S_INIT_COEFF, O_COEF, C_NONE, 8'h00, 0, 0, 0, 16'h0));
    tbl.push_back(v(S_INIT_CLK_GEN, O_CLK, C_NONE, 8'h00, 0, 0, 0, 16'h0));
    tbl.push_back(v(S_WAIT_CONN, O_NONE, C_CONN, 8'h00, 0, 1, 0, 16'h0));
    tbl.push_back(v(S_CONN_ACK, O_ACK, C_NONE, 8'h00, 0, 1, 0, 16'h0));
    tbl.push_back(v(S_CONN_ACK, O_ACK, C_NONE, 8'h00, 0, 0, 0, 16'h0));
    tbl.push_back(v(S_WAIT_CORR, O_NONE, C_SET, 8'h00, 0, 0, 0, 16'h0));
    tbl.push_back(v(S_WAIT_SAMPLE_BYTE, O_NONE, C_DATA, 8'h12, 0, 0, 0, 16'h0));
    tbl.push_back(v(S_WAIT_SAMPLE_BYTE, O_NONE, C_NONE, 8'h00, 0, 0, 1, 16'h0012));
    tbl.push_back(v(S_WAIT_SAMPLE_BYTE, O_NONE, C_DATA, 8'h34, 0, 1, 0, 16'h0));
    tbl.push_back(v(S_SET_SAMPLES, O_SETS, C_NONE, 8'h00, 0, 1, 1, 16'h1234));
    tbl.push_back(v(S_CONN_ACK, O_ACK, C_NONE, 8'h00, 0, 1, 0, 16'h0));
    tbl.push_back(v(S_CONN_ACK, O_ACK, C_NONE, 8'h00, 0, 0, 1, 16'h1234));
    tbl.push_back(v(S_WAIT_CORR, O_NONE, C_SET, 8'h00, 0, 0, 0, 16'h0));
    tbl.push_back(v(S_WAIT_SAMPLE_BYTE, O_NONE, C_DSW, 8'hAB, 0, 0, 0, 16'h0));
    tbl.push_back(v(S_WAIT_SAMPLE_BYTE, O_NONE, C_DATA, 8'hCD, 0, 0, 0, 16'h0));
    tbl.push_back(v(S_SET_SAMPLES, O_SETS, C_NONE, 8'h00, 0, 0, 1, 16'hABCD));
    tbl.push_back(v(S_CONN_ACK, O_ACK, C_NONE, 8'h00, 0, 0, 0, 16'h0));
    tbl.push_back(v(S_WAIT_CORR, O_NONE, C_DATA, 8'h55, 0, 0, 0, 16'h0));
    tbl.push_back(v(S_WAIT_CORR, O_NONE, C_NONE, 8'h00, 0, 0, 1, 16'hABCD));

    foreach (tbl[i]) begin
      step();
      chk($sformatf("vec%0d.cs", i), 32'(dut.cs_q), 32'(tbl[i].exp_cs));
      chk($sformatf("vec%0d.outs", i), 32'(outs()), 32'(tbl[i].exp_o));
      if (tbl[i].chk_sc) chk($sformatf("vec%0d.sc", i), 32'(bus.sample_cnt), 32'(tbl[i].exp_sc));
      cmd(tbl[i].cmd, tbl[i].rx);
      bus.coeff_busy = tbl[i].cb;
      bus.uart_busy  = tbl[i].ub;
    end

    // Correlation run: SEND0 only once every corr_busy bit has dropped.
    step(); chk_st("run.wc", S_WAIT_CORR, O_NONE); cmd(C_STRT, 8'h00);
    step(); chk_st("run.el0", S_ELAB0, O_EL0); cmd(C_NONE, 8'h00);
    step(); chk_st("run.wcb0", S_WAIT_CORR_BUSY, O_NONE);
    step(); chk_st("run.wcb1", S_WAIT_CORR_BUSY, O_NONE);
    step(); chk_st("run.wcb2", S_WAIT_CORR_BUSY, O_NONE); bus.corr_busy = 4'b0101;
    step(); chk_st("run.el1a", S_ELAB1, O_NONE);
    step(); chk_st("run.el1b", S_ELAB1, O_NONE); bus.corr_busy = 4'b0100;
    for (int i = 0; i < 3; i++) begin step(); chk_st("run.el1c", S_ELAB1, O_NONE); end
    bus.corr_busy = 4'b0000;
    for (int k = 0; k < NUM_CH; k++) send_one(k);
    step(); chk_st("run.done", S_WAIT_CONN, O_NONE);

    // Watchdog expiry with corr_busy held low.
    cmd(C_CONN, 8'h00);
    step(); chk_st("to.ack", S_CONN_ACK, O_ACK); cmd(C_NONE, 8'h00);
    step(); chk_st("to.wc", S_WAIT_CORR, O_NONE); bus.start_button = 1'b1;
    step(); chk_st("to.el0", S_ELAB0, O_EL0); bus.start_button = 1'b0;
    n = 0;
    step();
    while (dut.cs_q == S_WAIT_CORR_BUSY && n < 100) begin n++; step(); end
    chk("to.cycles", 32'(n), 32'(TIMEOUT));
    chk_st("to.rst", S_RESET_CORR, O_RST);
    chk("to.terr", 32'(bus.timeout_err), 32'h1);
    step(); chk_st("to.ic", S_INIT_COEFF, O_COEF);
    step(); chk_st("to.clk", S_INIT_CLK_GEN, O_CLK);
    step(); chk_st("to.wconn", S_WAIT_CONN, O_NONE);
    chk("to.terr_hold", 32'(bus.timeout_err), 32'h1); cmd(C_CONN, 8'h00);
    step(); chk("to.terr_clr", 32'(bus.timeout_err), 32'h0); cmd(C_NONE, 8'h00);

    // sw_reset while waiting for channels to finish; sample_cnt survives.
    step(); chk_st("swr.wc", S_WAIT_CORR, O_NONE); cmd(C_STRT, 8'h00);
    step(); chk_st("swr.el0", S_ELAB0, O_EL0); cmd(C_NONE, 8'h00); bus.corr_busy = 4'b1111;
    step(); chk_st("swr.wcb", S_WAIT_CORR_BUSY, O_NONE);
    step(); chk_st("swr.el1", S_ELAB1, O_NONE); cmd(C_DSW, 8'h00);
    step(); chk_st("swr.rst", S_RESET_CORR, O_RST); cmd(C_NONE, 8'h00); bus.corr_busy = '0;
    chk("swr.sc", 32'(bus.sample_cnt), 32'hABCD);
    step(); step();
    step(); chk_st("swr.wconn", S_WAIT_CONN, O_NONE); cmd(C_CONN, 8'h00);
    step(); cmd(C_NONE, 8'h00);
    // start_button beats a simultaneous sw_reset.
    step(); chk_st("pri.wc", S_WAIT_CORR, O_NONE); cmd(C_DSW, 8'h00); bus.start_button = 1'b1;
    step(); chk_st("pri.el0", S_ELAB0, O_EL0); cmd(C_NONE, 8'h00); bus.start_button = 1'b0;
    bus.corr_busy = 4'b0001;
    step(); chk_st("pri.wcb", S_WAIT_CORR_BUSY, O_NONE);
    step(); chk_st("pri.el1", S_ELAB1, O_NONE); bus.corr_busy = '0;
    send_one(0);
    send_one(1);

    // Async reset mid-SEND1 on channel 2, checked between clock edges.
    step(); chk_st("ar.send0", S_SEND0, O_S0); bus.send_busy = 1'b1;
    step(); chk_st("ar.send1", S_SEND1, O_S1);
    chk("ar.ch_pre", 32'(bus.send_ch), 32'h2);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("ar.cs", 32'(dut.cs_q), 32'(S_RESET_CORR));
    chk("ar.ch", 32'(bus.send_ch), 32'h0);
    chk("ar.terr", 32'(bus.timeout_err), 32'h0);
    chk("ar.sc", 32'(bus.sample_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1, "timeout");
  end
endmodule
